// File: rtl/vid_timing_pattern_gen.sv
// Video timing generator with shadowed end points, sync polarity, test patterns and VRST lock.
// Latency: O_PIX_REQ is combinational from the counters; DE/HS/VS/counts/pixel data register one cycle later.
// Backpressure: none; free-running at the pixel clock, the source must supply I_PIX_DATA whenever O_PIX_REQ=1.
module vid_timing_pattern_gen #(
  parameter int CH_W      = 8,
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 12,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int BAR_SHIFT = 6,
  parameter int CHK_SHIFT = 5
) (
  input  logic                     I_PCLK,
  input  logic                     I_RST,
  input  logic [NUM_CH*CH_W-1:0]   I_PIX_DATA,
  input  logic [1:0]               I_TP_MODE,
  input  logic [CNT_W-1:0]         I_HS_END,
  input  logic [CNT_W-1:0]         I_HBP_END,
  input  logic [CNT_W-1:0]         I_HACT_END,
  input  logic [CNT_W-1:0]         I_HFP_END,
  input  logic [CNT_W-1:0]         I_VS_END,
  input  logic [CNT_W-1:0]         I_VBP_END,
  input  logic [CNT_W-1:0]         I_VACT_END,
  input  logic [CNT_W-1:0]         I_VFP_END,
  input  logic                     I_VRST,
  output logic                     O_PIX_REQ,
  output logic                     O_DE,
  output logic                     O_HS,
  output logic                     O_VS,
  output logic [CNT_W-1:0]         O_HCNT,
  output logic [CNT_W-1:0]         O_VCNT,
  output logic [NUM_CH*CH_W-1:0]   O_PIX_DATA,
  output logic                     O_LOCKED
);

  localparam int   DW     = NUM_CH * CH_W;
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);
  // Only the low bits of the pixel x coordinate feed the pattern generators.
  localparam int   XW0    = (BAR_SHIFT + 3 > CH_W) ? BAR_SHIFT + 3 : CH_W;
  localparam int   XW     = (XW0 > CHK_SHIFT + 1) ? XW0 : CHK_SHIFT + 1;

  // Shadow copies of the timing end points and pattern mode, stable for a whole frame.
  logic [CNT_W-1:0] hs_end_q, hbp_end_q, hact_end_q, hfp_end_q;
  logic [CNT_W-1:0] vs_end_q, vbp_end_q, vact_end_q, vfp_end_q;
  logic [1:0]       mode_q;

  logic [CNT_W-1:0] hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic             vrst_q;

  logic             de_q, hs_q, vs_q, locked_q;
  logic [CNT_W-1:0] ohcnt_q, ovcnt_q;
  logic [DW-1:0]    pix_q, pix_d;

  logic             h_wrap, v_wrap, frame_end, vrst_edge, reload;
  logic             hs_reg, vs_reg, act;
  logic [XW-1:0]    x;
  logic             chk_y;
  logic [2:0]       bar_c;
  logic [DW-1:0]    bar_pix, grad_pix, chk_pix;

  assign h_wrap    = (hcnt_q == hfp_end_q);
  assign v_wrap    = (vcnt_q == vfp_end_q);
  assign frame_end = h_wrap && v_wrap;
  assign vrst_edge = I_VRST && !vrst_q;
  assign reload    = frame_end || vrst_edge;

  // Region decode from the live counters.
  assign hs_reg = (hcnt_q <= hs_end_q);
  assign vs_reg = (vcnt_q <= vs_end_q);
  assign act    = (hcnt_q > hbp_end_q) && (hcnt_q <= hact_end_q) &&
                  (vcnt_q > vbp_end_q) && (vcnt_q <= vact_end_q);

  // Pixel coordinates relative to the first active pixel; meaningful only while act=1.
  assign x     = XW'(hcnt_q - hbp_end_q - CNT_W'(1));
  assign chk_y = 1'((vcnt_q - vbp_end_q - CNT_W'(1)) >> CHK_SHIFT);
  assign bar_c = 3'd7 - x[BAR_SHIFT+2:BAR_SHIFT];

  // Channel 0 occupies the most significant bits.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int LSB = (NUM_CH - 1 - g) * CH_W;
    if (g < 3) begin : g_bar
      assign bar_pix[LSB +: CH_W] = {CH_W{bar_c[2-g]}};
    end else begin : g_nobar
      assign bar_pix[LSB +: CH_W] = '0;
    end
    assign grad_pix[LSB +: CH_W] = x[CH_W-1:0];
  end

  assign chk_pix = {DW{x[CHK_SHIFT] ^ chk_y}};

  // Select the outgoing pixel for the captured mode; blank outside the active window.
  always_comb begin
    pix_d = '0;
    if (act) begin
      case (mode_q)
        2'd0:    pix_d = I_PIX_DATA;
        2'd1:    pix_d = bar_pix;
        2'd2:    pix_d = grad_pix;
        default: pix_d = chk_pix;
      endcase
    end
  end

  // Counter next state: a VRST edge forces a frame restart, otherwise wrap at the end points.
  always_comb begin
    hcnt_d = hcnt_q + CNT_W'(1);
    vcnt_d = vcnt_q;
    if (vrst_edge) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = v_wrap ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  // Counters and shadow registers; shadows reload on reset and at every frame start.
  always_ff @(posedge I_PCLK) begin
    if (I_RST || reload) begin
      hs_end_q   <= I_HS_END;
      hbp_end_q  <= I_HBP_END;
      hact_end_q <= I_HACT_END;
      hfp_end_q  <= I_HFP_END;
      vs_end_q   <= I_VS_END;
      vbp_end_q  <= I_VBP_END;
      vact_end_q <= I_VACT_END;
      vfp_end_q  <= I_VFP_END;
      mode_q     <= I_TP_MODE;
    end
    if (I_RST) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Registered video outputs, one cycle behind the decode.
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      de_q    <= 1'b0;
      hs_q    <= ~HS_ACT;
      vs_q    <= ~VS_ACT;
      ohcnt_q <= '0;
      ovcnt_q <= '0;
      pix_q   <= '0;
    end else begin
      de_q    <= act;
      hs_q    <= hs_reg ? HS_ACT : ~HS_ACT;
      vs_q    <= vs_reg ? VS_ACT : ~VS_ACT;
      ohcnt_q <= hcnt_q;
      ovcnt_q <= vcnt_q;
      pix_q   <= pix_d;
    end
  end

  // VRST edge tracking; lock means the edge landed exactly on the natural frame wrap.
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      vrst_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      vrst_q <= I_VRST;
      if (vrst_edge) begin
        locked_q <= frame_end;
      end
    end
  end

  assign O_PIX_REQ  = act;
  assign O_DE       = de_q;
  assign O_HS       = hs_q;
  assign O_VS       = vs_q;
  assign O_HCNT     = ohcnt_q;
  assign O_VCNT     = ovcnt_q;
  assign O_PIX_DATA = pix_q;
  assign O_LOCKED   = locked_q;

endmodule

// File: tb/tb_vid_timing_pattern_gen.sv
// Self-checking bench for vid_timing_pattern_gen with a frame-position reference model.
// Latency: model predicts registered outputs one cycle after the inputs/state that produce them.
// Backpressure: none; stimulus is applied every pixel clock.
module tb_vid_timing_pattern_gen;

  localparam int BAR = 1;
  localparam int CHK = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic [1:0]  tp_mode = 2'd0;
  logic [11:0] hs_e, hbp_e, hact_e, hfp_e, vs_e, vbp_e, vact_e, vfp_e;
  logic        vrst = 1'b0;

  logic        o_req, o_de, o_hs, o_vs, o_locked;
  logic [11:0] o_hcnt, o_vcnt;
  logic [23:0] o_pix;
  logic [52:0] dut_vec, exp_vec;

  int asserts = 0;
  int fails   = 0;

  // Reference model: position within the frame plus the captured frame parameters.
  int m_p = 0;
  int m_hs = 1, m_hbp = 3, m_hact = 11, m_hfp = 13;
  int m_vs = 0, m_vbp = 1, m_vact = 5, m_vfp = 6;
  int m_mode = 0;
  bit m_vrst_prev = 0, m_locked = 0;
  int last_h = 0, last_v = 0;

  always #5 clk = ~clk;

  vid_timing_pattern_gen #(
    .CH_W(8), .NUM_CH(3), .CNT_W(12), .HS_POL(0), .VS_POL(0),
    .BAR_SHIFT(BAR), .CHK_SHIFT(CHK)
  ) dut (
    .I_PCLK(clk), .I_RST(rst), .I_PIX_DATA(pix_data), .I_TP_MODE(tp_mode),
    .I_HS_END(hs_e), .I_HBP_END(hbp_e), .I_HACT_END(hact_e), .I_HFP_END(hfp_e),
    .I_VS_END(vs_e), .I_VBP_END(vbp_e), .I_VACT_END(vact_e), .I_VFP_END(vfp_e),
    .I_VRST(vrst),
    .O_PIX_REQ(o_req), .O_DE(o_de), .O_HS(o_hs), .O_VS(o_vs),
    .O_HCNT(o_hcnt), .O_VCNT(o_vcnt), .O_PIX_DATA(o_pix), .O_LOCKED(o_locked)
  );

  assign dut_vec = {o_req, o_de, o_hs, o_vs, o_hcnt, o_vcnt, o_pix, o_locked};

  function automatic bit in_act(int h, int v);
    return (h > m_hbp) && (h <= m_hact) && (v > m_vbp) && (v <= m_vact);
  endfunction

  function automatic logic [23:0] pattern(int mode, int x, int y, logic [23:0] src);
    int col;
    logic [23:0] r;
    case (mode)
      0: r = src;
      1: begin
        col = 7 - ((x >> BAR) % 8);
        r = {((col / 4) % 2 != 0) ? 8'hFF : 8'h00,
             ((col / 2) % 2 != 0) ? 8'hFF : 8'h00,
             (col % 2 != 0)       ? 8'hFF : 8'h00};
      end
      2: r = {3{8'(x % 256)}};
      default: r = ((((x >> CHK) + (y >> CHK)) % 2) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
    return r;
  endfunction

  task automatic load_params();
    m_hs = int'(hs_e);  m_hbp = int'(hbp_e);  m_hact = int'(hact_e);  m_hfp = int'(hfp_e);
    m_vs = int'(vs_e);  m_vbp = int'(vbp_e);  m_vact = int'(vact_e);  m_vfp = int'(vfp_e);
    m_mode = int'(tp_mode);
  endtask

  // One pixel clock: predict registered outputs, clock the DUT, advance the model.
  task automatic tick();
    int ll, fl, h, v;
    bit a, e_de, e_hs, e_vs, edge_v;
    logic [23:0] pd;
    logic [11:0] e_hc, e_vc;
    ll = m_hfp + 1;
    fl = ll * (m_vfp + 1);
    h = m_p % ll;
    v = m_p / ll;
    a = in_act(h, v);
    if (rst) begin
      e_de = 0; e_hs = 1; e_vs = 1; e_hc = '0; e_vc = '0; pd = '0;
    end else begin
      e_de = a;
      e_hs = (h <= m_hs) ? 1'b0 : 1'b1;
      e_vs = (v <= m_vs) ? 1'b0 : 1'b1;
      e_hc = 12'(h);
      e_vc = 12'(v);
      pd = a ? pattern(m_mode, h - m_hbp - 1, v - m_vbp - 1, pix_data) : 24'h0;
    end
    last_h = h;
    last_v = v;
    @(posedge clk);
    #1;
    if (rst) begin
      m_p = 0; load_params(); m_vrst_prev = 0; m_locked = 0;
    end else begin
      edge_v = vrst && !m_vrst_prev;
      m_vrst_prev = vrst;
      if (edge_v) begin
        m_locked = (m_p == fl - 1);
        m_p = 0;
        load_params();
      end else if (m_p == fl - 1) begin
        m_p = 0;
        load_params();
      end else begin
        m_p++;
      end
    end
    ll = m_hfp + 1;
    exp_vec = {in_act(m_p % ll, m_p / ll), e_de, e_hs, e_vs, e_hc, e_vc, pd, m_locked};
  endtask

  task automatic set_timing(int hact, int hfp);
    hs_e = 12'd1; hbp_e = 12'd3; hact_e = 12'(hact); hfp_e = 12'(hfp);
    vs_e = 12'd0; vbp_e = 12'd1; vact_e = 12'd5;     vfp_e = 12'd6;
  endtask

  // Advance until the model sits at a frame start with the requested mode and line end.
  task automatic sync_frame(int mode, int hfp);
    int n = 0;
    while (!(m_mode == mode && m_hfp == hfp && m_p == 0) && n < 500) begin
      pix_data = 24'($urandom);
      tick();
      n++;
    end
    if (n >= 500) begin
      fails++;
      $display("FAIL sync_timeout mode=%0d hfp=%0d got_mode=%0d got_hfp=%0d", mode, hfp, m_mode, m_hfp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_timing(11, 13);
    tp_mode = 2'd0;
    for (int k = 0; k < 3; k++) tick();
    if (dut_vec !== exp_vec) begin
      fails++; $display("FAIL reset_vec dut=%h exp=%h", dut_vec, exp_vec);
    end
    asserts++;
    if ({o_req, o_de, o_hs, o_vs, o_locked} !== 5'b00110) begin
      fails++; $display("FAIL reset_ctl got=%b want=00110", {o_req, o_de, o_hs, o_vs, o_locked});
    end
    asserts++;
    if ({o_hcnt, o_vcnt, o_pix} !== 48'h0) begin
      fails++; $display("FAIL reset_data got=%h want=0", {o_hcnt, o_vcnt, o_pix});
    end
    asserts++;
  endtask

  task automatic test_timing();
    int de_n = 0, hs_lo = 0, vs_lo = 0, de_bad = 0;
    rst = 1'b0;
    for (int k = 0; k < 196; k++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL timing_vec t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec);
      end
      asserts++;
      if (k >= 98) begin
        de_n  += int'(o_de);
        hs_lo += int'(!o_hs);
        vs_lo += int'(!o_vs);
        if (o_de && (o_vcnt < 2 || o_vcnt > 5)) de_bad++;
      end
    end
    if (de_n !== 32) begin fails++; $display("FAIL timing_de_count got=%0d want=32", de_n); end
    asserts++;
    if (hs_lo !== 14) begin fails++; $display("FAIL timing_hs_low got=%0d want=14", hs_lo); end
    asserts++;
    if (vs_lo !== 14) begin fails++; $display("FAIL timing_vs_low got=%0d want=14", vs_lo); end
    asserts++;
    if (de_bad !== 0) begin fails++; $display("FAIL timing_de_lines got=%0d want=0", de_bad); end
    asserts++;
  endtask

  task automatic test_passthrough();
    logic [23:0] prev_pix;
    bit prev_req;
    for (int k = 0; k < 98; k++) begin
      prev_req = exp_vec[52];
      pix_data = 24'($urandom);
      prev_pix = pix_data;
      tick();
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL pass_vec t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec);
      end
      asserts++;
      if (o_de !== prev_req) begin
        fails++; $display("FAIL pass_de_follows_req got=%b want=%b", o_de, prev_req);
      end
      asserts++;
      if (o_pix !== (prev_req ? prev_pix : 24'h0)) begin
        fails++; $display("FAIL pass_data got=%h want=%h", o_pix, prev_req ? prev_pix : 24'h0);
      end
      asserts++;
    end
  endtask

  task automatic test_patterns();
    logic [23:0] want;
    bit chk;
    int x;
    set_timing(19, 21);
    for (int md = 1; md <= 3; md++) begin
      tp_mode = 2'(md);
      sync_frame(md, 21);
      for (int k = 0; k < 154; k++) begin
        pix_data = 24'($urandom);
        tick();
        if (dut_vec !== exp_vec) begin
          fails++; $display("FAIL pattern_vec mode=%0d dut=%h exp=%h", md, dut_vec, exp_vec);
        end
        asserts++;
        x = last_h - 4;
        chk = 1'b0;
        want = '0;
        if (md == 1 && last_v == 2) begin
          chk = 1'b1;
          case (x)
            0, 1:    want = 24'hFFFFFF;
            2, 3:    want = 24'hFFFF00;
            4, 5:    want = 24'hFF00FF;
            14, 15:  want = 24'h000000;
            default: chk = 1'b0;
          endcase
        end else if (md == 2 && last_v == 3 && x == 5) begin
          chk = 1'b1; want = 24'h050505;
        end else if (md == 3) begin
          if (last_v == 2 && x == 0) begin chk = 1'b1; want = 24'h000000; end
          if (last_v == 2 && x == 2) begin chk = 1'b1; want = 24'hFFFFFF; end
          if (last_v == 4 && x == 2) begin chk = 1'b1; want = 24'h000000; end
        end
        if (chk) begin
          if (o_pix !== want) begin
            fails++; $display("FAIL pattern_px mode=%0d x=%0d y=%0d got=%h want=%h", md, x, last_v - 2, o_pix, want);
          end
          asserts++;
        end
      end
    end
  endtask

  task automatic test_shadow();
    int n1 = 0, n2 = 0, max1 = 0, max2 = 0;
    set_timing(11, 13);
    tp_mode = 2'd0;
    sync_frame(0, 13);
    for (int k = 0; k < 40; k++) begin pix_data = 24'($urandom); tick(); end
    tp_mode = 2'd1;
    hfp_e = 12'd15;
    do begin
      pix_data = 24'($urandom); tick(); n1++;
      if (int'(o_hcnt) > max1) max1 = int'(o_hcnt);
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL shadow_vec dut=%h exp=%h", dut_vec, exp_vec);
      end
      asserts++;
    end while (!(o_hcnt == 0 && o_vcnt == 0) && n1 < 300);
    do begin
      pix_data = 24'($urandom); tick(); n2++;
      if (int'(o_hcnt) > max2) max2 = int'(o_hcnt);
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL shadow_vec2 dut=%h exp=%h", dut_vec, exp_vec);
      end
      asserts++;
    end while (!(o_hcnt == 0 && o_vcnt == 0) && n2 < 300);
    if (n1 !== 59) begin fails++; $display("FAIL shadow_old_frame got=%0d want=59", n1); end
    asserts++;
    if (n2 !== 112) begin fails++; $display("FAIL shadow_new_frame got=%0d want=112", n2); end
    asserts++;
    if (max1 !== 13 || max2 !== 15) begin
      fails++; $display("FAIL shadow_line_end got=%0d/%0d want=13/15", max1, max2);
    end
    asserts++;
  endtask

  task automatic test_vrst();
    int n = 0;
    hfp_e = 12'd13;
    sync_frame(1, 13);
    while (m_p != 3 * 14 + 5 && n < 200) begin tick(); n++; end
    vrst = 1'b1;
    tick();
    if (dut_vec !== exp_vec) begin fails++; $display("FAIL vrst_vec dut=%h exp=%h", dut_vec, exp_vec); end
    asserts++;
    if (o_locked !== 1'b0) begin fails++; $display("FAIL vrst_unlocked got=%b want=0", o_locked); end
    asserts++;
    tick();
    if ({o_hcnt, o_vcnt} !== 24'h0) begin
      fails++; $display("FAIL vrst_realign got=%0d,%0d want=0,0", o_hcnt, o_vcnt);
    end
    asserts++;
    vrst = 1'b0;
    n = 0;
    while (m_p != 97 && n < 200) begin tick(); n++; end
    vrst = 1'b1;
    tick();
    if (o_locked !== 1'b1) begin fails++; $display("FAIL vrst_locked got=%b want=1", o_locked); end
    asserts++;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL vrst_hold_vec dut=%h exp=%h", dut_vec, exp_vec);
      end
      asserts++;
    end
    if (o_locked !== 1'b1) begin fails++; $display("FAIL vrst_hold_lock got=%b want=1", o_locked); end
    asserts++;
    vrst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      pix_data = 24'($urandom);
      if ($urandom_range(0, 7) == 0) vrst = ~vrst;
      if ($urandom_range(0, 63) == 0) tp_mode = 2'($urandom_range(0, 3));
      tick();
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL random_vec t=%0t dut=%h exp=%h", $time, dut_vec, exp_vec);
      end
      asserts++;
    end
    vrst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(m_hfp == 13 && (m_p % 14) == 7 && (m_p / 14) == 3) && n < 400) begin tick(); n++; end
    rst = 1'b1;
    tick();
    if ({o_de, o_hs, o_vs, o_locked} !== 4'b0110) begin
      fails++; $display("FAIL midreset_ctl got=%b want=0110", {o_de, o_hs, o_vs, o_locked});
    end
    asserts++;
    if ({o_hcnt, o_vcnt, o_pix} !== 48'h0) begin
      fails++; $display("FAIL midreset_data got=%h want=0", {o_hcnt, o_vcnt, o_pix});
    end
    asserts++;
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL midreset_vec dut=%h exp=%h", dut_vec, exp_vec);
      end
      asserts++;
    end
  endtask

  initial begin
    set_timing(11, 13);
    test_reset();
    test_timing();
    test_passthrough();
    test_patterns();
    test_shadow();
    test_vrst();
    test_random();
    set_timing(11, 13);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/vid_timing_pattern_gen.md
Name: vid_timing_pattern_gen

Overview:
Parametrised successor to the video timing generator. It produces VGA-style HS/VS/DE timing from run-time programmable end points, and adds a pixel request strobe, shadowed timing registers, selectable sync polarity and four output modes (pass-through, colour bars, gradient, checkerboard). It also re-locks its counters to an external vertical reset and reports lock status. It sits at the back end of the edge-detection pipeline and drives the output video port.

Parameters:
CH_W, 8, bits per colour channel
NUM_CH, 3, number of channels; data width = NUM_CH*CH_W
CNT_W, 12, width of timing ports and counters
HS_POL, 0, active level of O_HS (1 = active high)
VS_POL, 0, active level of O_VS
BAR_SHIFT, 6, colour-bar width = 2^BAR_SHIFT pixels
CHK_SHIFT, 5, checker square size = 2^CHK_SHIFT pixels

Ports:
I_PCLK  in  1  pixel clock; the only clock
I_RST  in  1  reset, synchronous, active-high
I_PIX_DATA  in  NUM_CH*CH_W  source pixel; valid in the cycle O_PIX_REQ=1
I_TP_MODE  in  2  0 pass-through, 1 bars, 2 gradient, 3 checkerboard
I_HS_END, I_HBP_END, I_HACT_END, I_HFP_END  in  CNT_W each  horizontal end indices, inclusive
I_VS_END, I_VBP_END, I_VACT_END, I_VFP_END  in  CNT_W each  vertical end indices, inclusive
I_VRST  in  1  external frame reset; rising edge is significant
O_PIX_REQ  out  1  pixel request, one cycle ahead of O_DE
O_DE  out  1  data enable
O_HS  out  1  horizontal sync
O_VS  out  1  vertical sync
O_HCNT  out  CNT_W  horizontal count, aligned with O_DE
O_VCNT  out  CNT_W  vertical count, aligned with O_DE
O_PIX_DATA  out  NUM_CH*CH_W  output pixel
O_LOCKED  out  1  external vertical reset is in phase with internal timing

Behaviour:
- Reset values: hcnt=0, vcnt=0, O_PIX_REQ=0, O_DE=0, O_HS=~HS_POL, O_VS=~VS_POL, O_HCNT=0, O_VCNT=0, O_PIX_DATA=0, O_LOCKED=0, vrst_q=0.
- On reset, the shadow timing registers and the mode register load from the ports.
- Counters:
  - hcnt counts 0..hfp_end and then wraps to 0.
  - vcnt increments on each hcnt wrap and wraps to 0 after vfp_end.
- Frame start is the cycle in which both counters wrap. At frame start, all eight end points and I_TP_MODE are captured into shadow registers. Port changes mid-frame therefore have no effect until the next frame.
- Combinational region decode from the current counters:
  - hs = hcnt<=hs_end
  - vs = vcnt<=vs_end
  - act = (hbp_end<hcnt<=hact_end) && (vbp_end<vcnt<=vact_end)
- O_PIX_REQ = act, unregistered.
- Registered outputs, one cycle latency:
  - O_DE <= act
  - O_HS <= hs?HS_POL:~HS_POL
  - O_VS <= vs?VS_POL:~VS_POL
  - O_HCNT/O_VCNT <= hcnt/vcnt
- Pixel coordinates: x = hcnt-hbp_end-1, y = vcnt-vbp_end-1, each CNT_W wide. They are used only when act=1.
- O_PIX_DATA is registered. It is 0 when act=0. When act=1, it depends on the captured mode:
  - Mode 0: I_PIX_DATA.
  - Mode 1: b = x[BAR_SHIFT+2:BAR_SHIFT] and c = 7-b. Channel 0 (MSBs) = c[2]?all-ones:0, channel 1 = c[1], channel 2 = c[0]. Any channels beyond 3 = 0.
  - Mode 2: every channel = x[CH_W-1:0].
  - Mode 3: all channels = (x[CHK_SHIFT]^y[CHK_SHIFT]) ? all-ones : 0.
- VRST lock:
  - vrst_q <= I_VRST every cycle.
  - Edge condition: I_VRST && !vrst_q.
  - On an edge, the next counter state is forced to (0,0) and the shadow registers reload, as at a normal frame start.
  - O_LOCKED <= 1 if the counters were already at (hfp_end, vfp_end), i.e. a natural wrap; otherwise O_LOCKED <= 0.
  - O_LOCKED holds its value between edges.
  - A level held high never re-triggers.
- Reset has priority over everything. Reset asserted mid-frame gives reset values on the next edge.

Test Plan:
1. Use small timing (HS=1, HBP=3, HACT=11, HFP=13; VS=0, VBP=1, VACT=5, VFP=6), release reset -> 14-clock lines, 98-clock frames; O_HS low 2 clocks per line; O_DE high 8 clocks on lines 2..5, 32 per frame; O_VS low for line 0 only.
2. Mode 0, drive I_PIX_DATA = incrementing value each cycle -> O_PIX_DATA equals the value sampled with O_PIX_REQ=1 one cycle later; O_DE rises exactly one cycle after O_PIX_REQ; data is 0 outside DE.
3. Mode 1 with BAR_SHIFT=1 -> x=0,1 give FFFFFF; x=2,3 give FFFF00; x=4,5 give FF00FF; x=14,15 give 000000. Mode 3 with CHK_SHIFT=1 -> (x=0,y=0)=000000, (x=2,y=0)=FFFFFF, (x=2,y=2)=000000.
4. Switch I_TP_MODE 0->1 and change I_HFP_END 13->15 mid-frame -> the current frame is unchanged; the next frame shows bars with 16-clock lines.
5. I_VRST rising edge at hcnt=5, vcnt=3 -> next cycle counters are (0,0) and O_LOCKED=0. Next edge coincides with hcnt=13, vcnt=6 -> O_LOCKED=1. I_VRST held high for 200 clocks -> no further realignment.
6. Assert I_RST mid-active line -> next cycle O_DE=0, O_HS=1, O_VS=1, O_PIX_DATA=0, O_LOCKED=0, counters 0.
